data_mem_dma_arbiter: RTL and testbench
=======================================

// Module: data_mem_dma_arbiter
// PURPOSE
//  Shares the single-port data_mem between the CPU load/store path and a DMA burst engine.
//  Latches a DMA burst request (base word address, length, direction) and sequences one word per granted slot.
//  Drives data_mem's *_ctrl_by selects, write enable and DMA word addresses.
//  CPU has priority; a starvation counter forces DMA slots, stalling the CPU for one cycle.
// PARAMETERS
//  DATA_ADDR_WIDTH  32   width of DMA word-address outputs
//  NUM_WORDS        128  data_mem depth in words; DMA address wraps modulo NUM_WORDS
//  LEN_WIDTH        8    width of burst length (max NUM_WORDS beats)
//  MAX_STARVE       4    consecutive CPU-won RUN cycles before a DMA slot is forced (>=1)
// PORTS
//  cpu_clk                 in   1          clock, all state on posedge
//  cpu_rst_n               in   1          asynchronous active-low reset
//  cpu_mem_read            in   1          CPU load wants data_mem this cycle
//  cpu_mem_write           in   1          CPU store wants data_mem this cycle
//  cpu_stall               out  1          CPU access not serviced this cycle; hold request
//  dma_req                 in   1          start burst (sampled only in IDLE)
//  dma_we                  in   1          burst direction: 1 = write mem, 0 = read mem
//  dma_base_addr           in   AW         first word address of burst
//  dma_len                 in   LEN_WIDTH  number of words in burst
//  dma_busy                out  1          burst in progress (state RUN)
//  dma_beat                out  1          DMA owns data_mem this cycle; rdata valid / wdata consumed
//  dma_done                out  1          one-cycle pulse after last beat (or zero-length request)
//  dma_data_mem_raddr      out  AW         current DMA word address
//  dma_data_mem_waddr      out  AW         same value as dma_data_mem_raddr
//  data_mem_read_ctrl_by   out  1          0 = CPU, 1 = DMA
//  data_mem_write_ctrl_by  out  1          0 = CPU, 1 = DMA
//  data_mem_write          out  1          write enable to data_mem
// BEHAVIOUR
//  Reset: state IDLE, addr/remaining/starve_cnt = 0, dma_done = 0, dma_busy = 0; combinational outputs follow.
//  FSM states: IDLE, RUN. IDLE->RUN on dma_req && dma_len!=0 (latch base, len, we). IDLE stays IDLE on
//   dma_req && dma_len==0; dma_done pulses next cycle. RUN->IDLE at the edge ending the last beat.
//  cpu_busy = cpu_mem_read | cpu_mem_write.
//  dma_slot (comb) = RUN && (!cpu_busy || starve_cnt == MAX_STARVE).
//  read_ctrl_by = write_ctrl_by = dma_beat = dma_slot; cpu_stall = dma_slot && cpu_busy.
//  data_mem_write = dma_slot ? latched_we : cpu_mem_write.
//  Per beat edge: addr <= (addr+1 == NUM_WORDS) ? 0 : addr+1; remaining <= remaining-1; starve_cnt <= 0.
//  RUN cycle with CPU winning: starve_cnt <= starve_cnt+1 (saturates at MAX_STARVE). IDLE: starve_cnt <= 0.
//  Latency: first beat may occur the cycle after dma_req is sampled; an uncontended burst of N takes N cycles.
//  dma_done: registered; high exactly one cycle after the final beat edge; dma_busy low in that cycle.
//  dma_req while RUN is ignored; the requester re-asserts after dma_done.
//  Reset mid-burst aborts the burst immediately; no dma_done is issued.
//  Every CPU-stalled cycle has cpu_stall high; the CPU access is never silently dropped.
// CONFIGURATION
//  DATA_MEM_ARB_ABORT_EN defined: adds input dma_abort (1 bit).
//   dma_abort in RUN suppresses dma_slot that cycle. The next edge goes to IDLE, pulsing dma_done and dma_aborted (extra 1-bit output).
//   dma_abort in IDLE is ignored.
//  Not defined: no dma_abort / dma_aborted ports; a burst always runs to completion.
// TESTING
//  Idle CPU, req base=5 len=3 we=1 -> dma_beat 3 consecutive cycles, addr 5,6,7, data_mem_write=1; dma_done next cycle.
//  cpu_mem_read held high, burst len=2, MAX_STARVE=4 -> 4 CPU cycles, then 1 DMA beat with cpu_stall=1, repeated; done after 10 cycles.
//  base=126 len=4, NUM_WORDS=128 -> addresses 126,127,0,1.
//  dma_req with len=0 -> no beats, dma_busy stays 0, dma_done one pulse next cycle.
//  Assert cpu_rst_n low after 2 of 5 beats -> all outputs to reset values at once; no dma_done; ctrl_by=0.
//  With ABORT_EN, dma_abort on beat 3 of 6 -> no beat that cycle; dma_done and dma_aborted pulse next cycle; state IDLE.

Source files
------------

// File: rtl/data_mem_dma_arbiter.sv
// Arbitrates the single-port data_mem between CPU load/store and a DMA burst engine.
// Optional feature: define DATA_MEM_ARB_ABORT_EN to add dma_abort / dma_aborted.
module data_mem_dma_arbiter #(
    parameter int DATA_ADDR_WIDTH = 32,
    parameter int NUM_WORDS       = 128,
    parameter int LEN_WIDTH       = 8,
    parameter int MAX_STARVE      = 4
) (
    input  logic                       cpu_clk,
    input  logic                       cpu_rst_n,
    input  logic                       cpu_mem_read,
    input  logic                       cpu_mem_write,
    output logic                       cpu_stall,
    input  logic                       dma_req,
    input  logic                       dma_we,
    input  logic [DATA_ADDR_WIDTH-1:0] dma_base_addr,
    input  logic [LEN_WIDTH-1:0]       dma_len,
`ifdef DATA_MEM_ARB_ABORT_EN
    input  logic                       dma_abort,
    output logic                       dma_aborted,
`endif
    output logic                       dma_busy,
    output logic                       dma_beat,
    output logic                       dma_done,
    output logic [DATA_ADDR_WIDTH-1:0] dma_data_mem_raddr,
    output logic [DATA_ADDR_WIDTH-1:0] dma_data_mem_waddr,
    output logic                       data_mem_read_ctrl_by,
    output logic                       data_mem_write_ctrl_by,
    output logic                       data_mem_write
);

    localparam int SW = $clog2(MAX_STARVE + 1);
    localparam logic [SW-1:0]              STARVE_MAX = SW'(MAX_STARVE);
    localparam logic [DATA_ADDR_WIDTH-1:0] WRAP_AT    = DATA_ADDR_WIDTH'(NUM_WORDS);
    localparam logic [DATA_ADDR_WIDTH-1:0] ADDR_ONE   = DATA_ADDR_WIDTH'(1);
    localparam logic [LEN_WIDTH-1:0]       LEN_ONE    = LEN_WIDTH'(1);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t                       r_state;
    logic [DATA_ADDR_WIDTH-1:0]   r_addr;
    logic [LEN_WIDTH-1:0]         r_remaining;
    logic [SW-1:0]                r_starve;
    logic                         r_we;
    logic                         r_done;
`ifdef DATA_MEM_ARB_ABORT_EN
    logic                         r_aborted;
`endif

    logic                         w_cpu_busy;
    logic                         w_run;
    logic                         w_abort;
    logic                         w_slot;
    logic [DATA_ADDR_WIDTH-1:0]   w_addr_inc;
    logic [DATA_ADDR_WIDTH-1:0]   w_addr_next;

    assign w_cpu_busy = cpu_mem_read | cpu_mem_write;
    assign w_run      = (r_state == S_RUN);

`ifdef DATA_MEM_ARB_ABORT_EN
    assign w_abort = dma_abort;
`else
    assign w_abort = 1'b0;
`endif

    // An aborting cycle never owns the memory, so the CPU keeps it even when starved.
    assign w_slot      = w_run && !w_abort && (!w_cpu_busy || (r_starve == STARVE_MAX));
    assign w_addr_inc  = r_addr + ADDR_ONE;
    assign w_addr_next = (w_addr_inc == WRAP_AT) ? '0 : w_addr_inc;

    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_remaining <= '0;
            r_starve    <= '0;
            r_we        <= 1'b0;
            r_done      <= 1'b0;
`ifdef DATA_MEM_ARB_ABORT_EN
            r_aborted   <= 1'b0;
`endif
        end else begin
            // NOTE: pulse flags default low every edge and are set only where they fire;
            // all state here uses <= so every branch sees the pre-edge values.
            r_done <= 1'b0;
`ifdef DATA_MEM_ARB_ABORT_EN
            r_aborted <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    r_starve <= '0;
                    if (dma_req) begin
                        if (dma_len == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state     <= S_RUN;
                            r_addr      <= dma_base_addr;
                            r_remaining <= dma_len;
                            r_we        <= dma_we;
                        end
                    end
                end
                S_RUN: begin
`ifdef DATA_MEM_ARB_ABORT_EN
                    if (w_abort) begin
                        r_state   <= S_IDLE;
                        r_starve  <= '0;
                        r_done    <= 1'b1;
                        r_aborted <= 1'b1;
                    end else
`endif
                    if (w_slot) begin
                        r_addr      <= w_addr_next;
                        r_remaining <= r_remaining - LEN_ONE;
                        r_starve    <= '0;
                        if (r_remaining == LEN_ONE) begin
                            r_state <= S_IDLE;
                            r_done  <= 1'b1;
                        end
                    end else if (r_starve != STARVE_MAX) begin
                        r_starve <= r_starve + SW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign dma_busy               = w_run;
    assign dma_beat               = w_slot;
    assign dma_done               = r_done;
    assign dma_data_mem_raddr     = r_addr;
    assign dma_data_mem_waddr     = r_addr;
    assign data_mem_read_ctrl_by  = w_slot;
    assign data_mem_write_ctrl_by = w_slot;
    assign cpu_stall              = w_slot && w_cpu_busy;
    assign data_mem_write         = w_slot ? r_we : cpu_mem_write;
`ifdef DATA_MEM_ARB_ABORT_EN
    assign dma_aborted            = r_aborted;
`endif

endmodule

// File: tb/tb_data_mem_dma_arbiter.sv
// Directed + randomized bench for data_mem_dma_arbiter against a cycle-level burst model.
// Abort checks are built when DATA_MEM_ARB_ABORT_EN is defined.
module tb_data_mem_dma_arbiter;

    localparam int AW = 32;
    localparam int NW = 128;
    localparam int LW = 8;
    localparam int MS = 4;
`ifdef DATA_MEM_ARB_ABORT_EN
    localparam bit ABORT_ON = 1'b1;
`else
    localparam bit ABORT_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cpu_mem_read, cpu_mem_write, cpu_stall;
    logic          dma_req, dma_we;
    logic [AW-1:0] dma_base_addr;
    logic [LW-1:0] dma_len;
    logic          dma_busy, dma_beat, dma_done;
    logic [AW-1:0] raddr, waddr;
    logic          rctrl, wctrl, mem_write;
`ifdef DATA_MEM_ARB_ABORT_EN
    logic          dma_abort, dma_aborted;
`endif

    always #5 clk = ~clk;

    data_mem_dma_arbiter #(
        .DATA_ADDR_WIDTH(AW), .NUM_WORDS(NW), .LEN_WIDTH(LW), .MAX_STARVE(MS)
    ) dut (
        .cpu_clk(clk),
        .cpu_rst_n(rst_n),
        .cpu_mem_read(cpu_mem_read),
        .cpu_mem_write(cpu_mem_write),
        .cpu_stall(cpu_stall),
        .dma_req(dma_req),
        .dma_we(dma_we),
        .dma_base_addr(dma_base_addr),
        .dma_len(dma_len),
`ifdef DATA_MEM_ARB_ABORT_EN
        .dma_abort(dma_abort),
        .dma_aborted(dma_aborted),
`endif
        .dma_busy(dma_busy),
        .dma_beat(dma_beat),
        .dma_done(dma_done),
        .dma_data_mem_raddr(raddr),
        .dma_data_mem_waddr(waddr),
        .data_mem_read_ctrl_by(rctrl),
        .data_mem_write_ctrl_by(wctrl),
        .data_mem_write(mem_write)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Burst model: whole-burst bookkeeping in plain integers.
    bit m_busy, m_we, m_done, m_aborted;
    int m_addr, m_left, m_starve;

    // Observations taken from the DUT, compared later to spec constants.
    int g_step, g_beats, g_busy, g_stalls, g_dones, g_done_at;
    int addr_log[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_we = 0; m_done = 0; m_aborted = 0;
        m_addr = 0; m_left = 0; m_starve = 0;
    endtask

    task automatic clear_obs();
        g_step = 0; g_beats = 0; g_busy = 0; g_stalls = 0; g_dones = 0; g_done_at = -1;
        addr_log.delete();
    endtask

    task automatic step(input bit rd, input bit wr, input bit req, input bit we,
                        input int base, input int len, input bit abt);
        bit a, cpu_b, slot;
        a = abt & ABORT_ON;
        @(negedge clk);
        cpu_mem_read  = rd;
        cpu_mem_write = wr;
        dma_req       = req;
        dma_we        = we;
        dma_base_addr = AW'(base);
        dma_len       = LW'(len);
`ifdef DATA_MEM_ARB_ABORT_EN
        dma_abort     = a;
`endif
        #1;
        cpu_b = rd | wr;
        slot  = m_busy && !a && (!cpu_b || m_starve == MS);
        chk("busy",     dma_busy,  m_busy);
        chk("beat",     dma_beat,  slot);
        chk("done",     dma_done,  m_done);
        chk("raddr",    raddr,     m_addr);
        chk("waddr",    waddr,     m_addr);
        chk("rctrl",    rctrl,     slot);
        chk("wctrl",    wctrl,     slot);
        chk("stall",    cpu_stall, slot && cpu_b);
        chk("mem_write", mem_write, slot ? m_we : wr);
`ifdef DATA_MEM_ARB_ABORT_EN
        chk("aborted",  dma_aborted, m_aborted);
`endif
        if (dma_beat) begin
            g_beats++;
            addr_log.push_back(int'(raddr));
        end
        if (dma_busy)  g_busy++;
        if (cpu_stall) g_stalls++;
        if (dma_done) begin
            g_dones++;
            g_done_at = g_step;
        end
        g_step++;
        @(posedge clk);
        m_done = 0;
        m_aborted = 0;
        if (m_busy) begin
            if (a) begin
                m_busy = 0; m_done = 1; m_aborted = 1; m_starve = 0;
            end else if (slot) begin
                m_addr = (m_addr + 1) % NW;
                m_left--;
                m_starve = 0;
                if (m_left == 0) begin
                    m_busy = 0;
                    m_done = 1;
                end
            end else if (m_starve < MS) begin
                m_starve++;
            end
        end else begin
            m_starve = 0;
            if (req) begin
                if (len == 0) m_done = 1;
                else begin
                    m_busy = 1; m_addr = base; m_left = len; m_we = we;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        cpu_mem_read = 0; cpu_mem_write = 0; dma_req = 0; dma_we = 0;
        dma_base_addr = '0; dma_len = '0;
`ifdef DATA_MEM_ARB_ABORT_EN
        dma_abort = 0;
`endif
        model_reset();
        #2;
        chk("rst_busy", dma_busy, 1'b0);
        chk("rst_done", dma_done, 1'b0);
        chk("rst_beat", dma_beat, 1'b0);
        chk("rst_addr", raddr, 32'd0);
        chk("rst_ctrl", rctrl | wctrl, 1'b0);
        chk("rst_write", mem_write, 1'b0);
        #20 rst_n = 1'b1;

        // Uncontended write burst: base 5, length 3.
        clear_obs();
        step(0, 0, 1, 1, 5, 3, 0);
        idle(4);
        chk("b1_beats", g_beats, 3);
        chk("b1_a0", addr_log[0], 5);
        chk("b1_a1", addr_log[1], 6);
        chk("b1_a2", addr_log[2], 7);
        chk("b1_done_at", g_done_at, 4);

        // CPU load held high: starvation forces one DMA beat every fifth cycle.
        clear_obs();
        step(1, 0, 1, 0, 20, 2, 0);
        for (int i = 0; i < 12; i++) step(1, 0, 0, 0, 0, 0, 0);
        chk("st_busy", g_busy, 10);
        chk("st_beats", g_beats, 2);
        chk("st_stalls", g_stalls, 2);
        chk("st_done_at", g_done_at, 11);

        // Address wraps at the top of memory.
        clear_obs();
        step(0, 0, 1, 0, 126, 4, 0);
        idle(6);
        chk("wr_beats", g_beats, 4);
        chk("wr_a0", addr_log[0], 126);
        chk("wr_a1", addr_log[1], 127);
        chk("wr_a2", addr_log[2], 0);
        chk("wr_a3", addr_log[3], 1);

        // Zero-length request.
        clear_obs();
        step(0, 0, 1, 1, 9, 0, 0);
        idle(3);
        chk("z_busy", g_busy, 0);
        chk("z_beats", g_beats, 0);
        chk("z_dones", g_dones, 1);
        chk("z_done_at", g_done_at, 1);

        // Reset mid-burst after two of five beats.
        clear_obs();
        step(0, 0, 1, 1, 40, 5, 0);
        idle(2);
        chk("mr_beats", g_beats, 2);
        @(negedge clk);
        cpu_mem_read = 0; cpu_mem_write = 0; dma_req = 0;
        rst_n = 1'b0;
        #1;
        chk("mr_busy", dma_busy, 1'b0);
        chk("mr_beat", dma_beat, 1'b0);
        chk("mr_done", dma_done, 1'b0);
        chk("mr_addr", raddr, 32'd0);
        chk("mr_ctrl", rctrl | wctrl, 1'b0);
        chk("mr_write", mem_write, 1'b0);
        model_reset();
        @(posedge clk);
        #2 rst_n = 1'b1;
        clear_obs();
        idle(3);
        chk("mr_no_done", g_dones, 0);

`ifdef DATA_MEM_ARB_ABORT_EN
        // Abort on the third of six beats.
        clear_obs();
        step(0, 0, 1, 0, 10, 6, 0);
        idle(2);
        step(0, 0, 0, 0, 0, 0, 1);
        idle(3);
        chk("ab_beats", g_beats, 2);
        chk("ab_dones", g_dones, 1);
        chk("ab_done_at", g_done_at, 4);
`endif

        // Random traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            step($urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1,
                 int'($urandom_range(0, NW - 1)),
                 ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, NW)) : int'($urandom_range(0, 8)),
                 $urandom_range(0, 15) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
